cache_arbiter: RTL

- Shares one cacheline_adaptor / physical memory port between the L1 instruction cache (read-only) and the L1 data cache (read/write).
- Grants one requester at a time and captures its address and write line at grant.
- Drives the adaptor's LLC-side handshake and routes the 256-bit line and the response pulse back to the owner.
- Sits between both L1 caches and the cacheline_adaptor.

---
 rtl/cache_arb_pkg.sv | 11 +
 rtl/cache_arbiter_if.sv | 39 +++
 rtl/cache_arbiter_arb_grant.sv | 33 +++
 rtl/cache_arbiter.sv | 89 ++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the L1-to-adaptor cache arbiter.
package cache_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned LINE_W_DEF = 256;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RECOVER} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
    typedef enum logic {OP_READ, OP_WRITE} op_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of I-cache, D-cache and cacheline-adaptor signals around the arbiter.
interface cache_arbiter_if
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_line;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wline;
    logic [LINE_W-1:0] d_line;
    logic              d_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wline;
    logic [LINE_W-1:0] mem_rline;
    logic              mem_resp;

    // Arbiter side.
    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wline, mem_rline, mem_resp,
        output i_line, i_resp, d_line, d_resp, mem_read, mem_write, mem_address, mem_wline
    );

    // Caches and adaptor side.
    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wline, mem_rline, mem_resp,
        input  i_line, i_resp, d_line, d_resp, mem_read, mem_write, mem_address, mem_wline
    );

endinterface

// File: rtl/cache_arbiter_arb_grant.sv
// Owner selection between I and D requests.
// CACHE_ARB_RR_EN selects round-robin on contention; default is fixed D-over-I.
module arb_grant
    import cache_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output owner_t owner
);

`ifdef CACHE_ARB_RR_EN
    always_comb begin
        owner = OWN_I;
        if (i_req && d_req) begin
            owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            owner = OWN_D;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        owner = OWN_I;
        if (d_req) begin
            owner = OWN_D;
        end
    end
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Shares one cacheline adaptor between the L1 I-cache and D-cache, one owner at a time.
// Contention policy is set by CACHE_ARB_RR_EN (see arb_grant).
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
) (
    input logic            clk,
    input logic            reset_n,
    cache_arbiter_if.slave bus
);

    arb_state_t        state_q;
    owner_t            last_owner_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [LINE_W-1:0] mem_wline_q;

    logic   d_req;
    op_t    d_op;
    owner_t grant;

    assign d_req = bus.d_read | bus.d_write;
    assign d_op  = bus.d_write ? OP_WRITE : OP_READ;

    arb_grant u_grant (
        .i_req      (bus.i_read),
        .d_req      (d_req),
        .last_owner (last_owner_q),
        .owner      (grant)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_owner_q  <= OWN_I;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wline_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.i_read || d_req) begin
                        last_owner_q <= grant;
                        if (grant == OWN_D) begin
                            state_q       <= BUSY_D;
                            mem_address_q <= bus.d_address;
                            mem_read_q    <= (d_op == OP_READ);
                            mem_write_q   <= (d_op == OP_WRITE);
                            mem_wline_q   <= (d_op == OP_WRITE) ? bus.d_wline : '0;
                        end else begin
                            state_q       <= BUSY_I;
                            mem_address_q <= bus.i_address;
                            mem_read_q    <= 1'b1;
                            mem_write_q   <= 1'b0;
                            mem_wline_q   <= '0;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_resp) begin
                        state_q     <= RECOVER;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                    end
                end
                RECOVER: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wline   = mem_wline_q;

    // Response is passed straight through, but only to the current owner.
    always_comb begin
        bus.i_resp = (state_q == BUSY_I) && bus.mem_resp;
        bus.d_resp = (state_q == BUSY_D) && bus.mem_resp;
        bus.i_line = bus.i_resp ? bus.mem_rline : '0;
        bus.d_line = bus.d_resp ? bus.mem_rline : '0;
    end

endmodule
